// File: rtl/fsm_control_param_if.sv
// -----------------------------------------------------------------------------
// fsm_control_param_if
//
// Purpose: groups the flag, threshold and status signals that connect the
// flow-control FIFOs to the supervising control FSM.
//
// Parameters: NUM_FIFOS (supervised FIFOs, >= 1), UMBRAL_W (threshold width
// per FIFO), ERR_CNT_W (error-entry counter width).
//
// Signals:
//   init          request to (re)enter initialisation, level-sensitive
//   umbrales_in   thresholds, FIFO i at [i*UMBRAL_W +: UMBRAL_W]
//   fifo_error    per-FIFO error flag
//   fifo_empty    per-FIFO empty flag
//   umbrales_out  thresholds latched during INIT
//   state_out     current FSM state (RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4)
//   idle_out / active_out / error_out   one-hot status in IDLE/ACTIVE/ERROR
//   error_src     sticky record of FIFOs that raised an error
//   err_count     number of entries into ERROR
//
// Handshake semantics: there is no valid/ready pair on this bus. Every input
// is a level that the FSM samples on each rising clk edge, and every output
// is a register that is valid for the whole cycle after the edge that wrote it.
//
// Modports: master = flag/threshold producer, slave = the control FSM.
// -----------------------------------------------------------------------------
interface fsm_control_param_if #(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 4,
  parameter int ERR_CNT_W = 4
);
  logic                          init;
  logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_in;
  logic [NUM_FIFOS-1:0]          fifo_error;
  logic [NUM_FIFOS-1:0]          fifo_empty;
  logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_out;
  logic [2:0]                    state_out;
  logic                          idle_out;
  logic                          active_out;
  logic                          error_out;
  logic [NUM_FIFOS-1:0]          error_src;
  logic [ERR_CNT_W-1:0]          err_count;

  modport master (
    output init, umbrales_in, fifo_error, fifo_empty,
    input  umbrales_out, state_out, idle_out, active_out, error_out,
           error_src, err_count
  );

  modport slave (
    input  init, umbrales_in, fifo_error, fifo_empty,
    output umbrales_out, state_out, idle_out, active_out, error_out,
           error_src, err_count
  );
endinterface

// File: rtl/fsm_control_param.sv
// -----------------------------------------------------------------------------
// fsm_control_param
//
// Purpose: parametrised control FSM supervising NUM_FIFOS FIFOs. Latches the
// per-FIFO thresholds while in INIT, reports IDLE / ACTIVE / ERROR from the
// FIFO empty and error flags, and keeps a sticky record of erroring FIFOs.
//
// Ports:
//   clk      single clock, rising edge
//   reset_L  synchronous active-low reset
//   bus      fsm_control_param_if.slave (flags, thresholds, status outputs)
//
// Optional feature: define FSM_ERR_COUNT_EN to build a saturating counter of
// entries into ERROR on bus.err_count. Without it err_count is tied to 0.
//
// The state register is visible on bus.state_out for checkers.
// -----------------------------------------------------------------------------
module fsm_control_param #(
  parameter int NUM_FIFOS = 5,  // must be >= 1
  parameter int UMBRAL_W  = 4,
  parameter int ERR_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_L,
  fsm_control_param_if.slave     bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                        state_q;
  state_t                        state_d;
  logic                          idle_q;
  logic                          active_q;
  logic                          error_q;
  logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_q;
  logic [NUM_FIFOS-1:0]          error_src_q;

  logic any_err;
  logic all_empty;

  assign any_err   = |bus.fifo_error;
  assign all_empty = &bus.fifo_empty;

  // Next-state logic. init overrides everything except reset (reset is
  // applied in the register process). Error is evaluated before the empty
  // flags so a simultaneous error always wins.
  always_comb begin
    state_d = ST_RESET;
    if (bus.init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = any_err ? ST_ERROR : ST_IDLE;
        ST_IDLE: begin
          if (any_err)         state_d = ST_ERROR;
          else if (!all_empty) state_d = ST_ACTIVE;
          else                 state_d = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (any_err)        state_d = ST_ERROR;
          else if (all_empty) state_d = ST_IDLE;
          else                state_d = ST_ACTIVE;
        end
        ST_ERROR:  state_d = ST_ERROR;  // absorbing; left only via init/reset
        default:   state_d = ST_RESET;  // encodings 5..7 recover through RESET
      endcase
    end
  end

  // State register and status flags. The flags decode state_d so they change
  // on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  // Thresholds follow the input on every edge spent in INIT and hold elsewhere.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      umbrales_q <= '0;
    end else if (state_q == ST_INIT) begin
      umbrales_q <= bus.umbrales_in;
    end
  end

  // Sticky error record. It accumulates in every operational state; an init
  // request clears it on the edge that moves the FSM into INIT. In RESET it
  // stays at its cleared value.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      error_src_q <= '0;
    end else if (state_q == ST_INIT || state_q == ST_IDLE ||
                 state_q == ST_ACTIVE || state_q == ST_ERROR) begin
      if (bus.init) error_src_q <= '0;
      else          error_src_q <= error_src_q | bus.fifo_error;
    end
  end

`ifdef FSM_ERR_COUNT_EN
  logic                 enter_err;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Only entries from INIT/IDLE/ACTIVE count; staying in ERROR does not.
  assign enter_err = (state_d == ST_ERROR) &&
                     (state_q == ST_INIT || state_q == ST_IDLE ||
                      state_q == ST_ACTIVE);

  // Saturating counter, cleared only by reset (init leaves it alone).
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      err_cnt_q <= '0;
    end else if (enter_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

  assign bus.state_out    = state_q;
  assign bus.idle_out     = idle_q;
  assign bus.active_out   = active_q;
  assign bus.error_out    = error_q;
  assign bus.umbrales_out = umbrales_q;
  assign bus.error_src    = error_src_q;

endmodule

// File: tb/tb_fsm_control_param.sv
// -----------------------------------------------------------------------------
// tb_fsm_control_param
//
// Directed scenarios followed by a randomized phase. A behavioural model of
// the supervisor (plain integers for the mode, sticky mask, saturating count)
// predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_fsm_control_param;
  localparam int N  = 5;
  localparam int UW = 4;
  localparam int CW = 2;
  localparam int UMB_BITS = N * UW;
  localparam int CNT_MAX  = (1 << CW) - 1;
  localparam logic [N-1:0] ALL_EMPTY = {N{1'b1}};

  // Mode numbers as published on state_out.
  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  fsm_control_param_if #(.NUM_FIFOS(N), .UMBRAL_W(UW), .ERR_CNT_W(CW)) bus ();

  fsm_control_param #(.NUM_FIFOS(N), .UMBRAL_W(UW), .ERR_CNT_W(CW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int                  m_mode = M_RESET;
  logic [UMB_BITS-1:0] m_umb  = '0;
  logic [N-1:0]        m_src  = '0;
  int                  m_cnt  = 0;

  // Advance the model by one edge using the inputs about to be sampled.
  task automatic model_edge();
    int prev;
    int nxt;
    bit err;
    bit operational;
    prev = m_mode;
    err  = (bus.fifo_error != '0);
    if (!reset_L) begin
      m_mode = M_RESET;
      m_umb  = '0;
      m_src  = '0;
      m_cnt  = 0;
      return;
    end
    if (bus.init)                nxt = M_INIT;
    else if (prev == M_RESET)    nxt = M_INIT;
    else if (prev == M_INIT)     nxt = err ? M_ERROR : M_IDLE;
    else if (prev == M_IDLE)     nxt = err ? M_ERROR :
                                       (bus.fifo_empty != ALL_EMPTY) ? M_ACTIVE : M_IDLE;
    else if (prev == M_ACTIVE)   nxt = err ? M_ERROR :
                                       (bus.fifo_empty == ALL_EMPTY) ? M_IDLE : M_ACTIVE;
    else                         nxt = M_ERROR;

    if (prev == M_INIT) m_umb = bus.umbrales_in;
    operational = (prev != M_RESET);
    if (operational) m_src = bus.init ? '0 : (m_src | bus.fifo_error);
`ifdef FSM_ERR_COUNT_EN
    if ((prev == M_INIT || prev == M_IDLE || prev == M_ACTIVE) &&
        nxt == M_ERROR && m_cnt < CNT_MAX)
      m_cnt = m_cnt + 1;
`endif
    m_mode = nxt;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".state"},  32'(bus.state_out),    32'(m_mode));
    chk({ph, ".idle"},   32'(bus.idle_out),     32'(m_mode == M_IDLE));
    chk({ph, ".active"}, 32'(bus.active_out),   32'(m_mode == M_ACTIVE));
    chk({ph, ".error"},  32'(bus.error_out),    32'(m_mode == M_ERROR));
    chk({ph, ".umb"},    32'(bus.umbrales_out), 32'(m_umb));
    chk({ph, ".src"},    32'(bus.error_src),    32'(m_src));
    chk({ph, ".cnt"},    32'(bus.err_count),    32'(m_cnt));
  endtask

  // ---------------- driver ----------------
  // Inputs are changed 1ns after a rising edge; outputs are sampled there too.
  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_cnt;
    reset_L         = 1'b0;
    bus.init        = 1'b1;
    bus.fifo_error  = 5'h1F;
    bus.fifo_empty  = 5'h00;
    bus.umbrales_in = 20'hFFFFF;

    // Reset dominates init and errors.
    step("rst0");
    step("rst1");
    chk("rst_state_zero", 32'(bus.state_out), 32'd0);
    chk("rst_umb_zero",   32'(bus.umbrales_out), 32'd0);

    // Release: one edge to INIT.
    reset_L         = 1'b1;
    bus.init        = 1'b0;
    bus.fifo_error  = 5'h00;
    bus.fifo_empty  = 5'h1F;
    bus.umbrales_in = 20'hA5C3E;
    step("release");
    chk("release_init", 32'(bus.state_out), 32'd1);

    // Init latch.
    bus.init = 1'b1;
    for (int i = 0; i < 3; i++) step("init_hold");
    bus.init = 1'b0;
    step("init_exit");
    chk("init_umb", 32'(bus.umbrales_out), 32'hA5C3E);
    chk("init_idle", 32'(bus.idle_out), 32'd1);
    bus.umbrales_in = 20'h00000;
    step("umb_hold0");
    step("umb_hold1");
    chk("umb_held", 32'(bus.umbrales_out), 32'hA5C3E);

    // Activity.
    bus.fifo_empty = 5'h1D;
    step("to_active");
    chk("active_flag", 32'(bus.active_out), 32'd1);
    bus.fifo_empty = 5'h1F;
    step("to_idle");
    chk("idle_again", 32'(bus.state_out), 32'd2);

    // Error capture from ACTIVE, then ERROR absorbs.
    bus.fifo_empty = 5'h1D;
    step("active2");
    bus.fifo_error = 5'h04;
    step("err_in");
    chk("err_src_04", 32'(bus.error_src), 32'h04);
    bus.fifo_error = 5'h00;
    bus.fifo_empty = 5'h1F;
    for (int i = 0; i < 10; i++) step("err_stay");
    chk("err_absorb", 32'(bus.error_out), 32'd1);

    // Recover, then error beats activity from IDLE.
    bus.init = 1'b1;
    step("recover");
    bus.init = 1'b0;
    step("recover_idle");
    bus.fifo_error = 5'h10;
    bus.fifo_empty = 5'h00;
    step("err_prio");
    chk("err_prio_state", 32'(bus.state_out), 32'd4);
    bus.fifo_error = 5'h00;
    bus.init = 1'b1;
    step("prio_recover");
    chk("recover_src_clear", 32'(bus.error_src), 32'd0);
    bus.init = 1'b0;

    // Counter: five entries after a fresh reset, each recovered via init.
    reset_L = 1'b0;
    step("cnt_rst");
    reset_L = 1'b1;
    step("cnt_rel");
    for (int i = 0; i < 5; i++) begin
      bus.init = 1'b1;
      bus.fifo_error = 5'h00;
      step("cnt_init");
      bus.init = 1'b0;
      bus.fifo_error = 5'h01;
      step("cnt_err");
`ifdef FSM_ERR_COUNT_EN
      exp_cnt = (i < CNT_MAX) ? i + 1 : CNT_MAX;
`else
      exp_cnt = 0;
`endif
      chk("cnt_value", 32'(bus.err_count), 32'(exp_cnt));
    end
    bus.fifo_error = 5'h00;

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      reset_L         = ($urandom_range(0, 49) != 0);
      bus.init        = ($urandom_range(0, 19) == 0);
      bus.fifo_error  = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      bus.fifo_empty  = ($urandom_range(0, 1) == 0) ? ALL_EMPTY : N'($urandom);
      bus.umbrales_in = UMB_BITS'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_control_param.md
# fsm_control_param

Parametrised control state machine for the flow-control datapath. It supervises N FIFOs and latches their per-FIFO thresholds during initialisation. It reports IDLE, ACTIVE or ERROR status from the FIFO empty and error flags, and records which FIFOs have raised an error. It sits between the flow-control blocks, which drive the empty and error flags, and the blocks that consume `umbrales_out` and the status outputs.

## Interface
- `NUM_FIFOS`, default 5: number of supervised FIFOs; must be ≥1.
- `UMBRAL_W`, default 4: threshold width per FIFO.
- `ERR_CNT_W`, default 4: width of the error-entry counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_L`  in  1  synchronous, active-low reset.
- `init`  in  1  initialisation request, level-sensitive.
- `umbrales_in`  in  NUM_FIFOS*UMBRAL_W  thresholds; FIFO i occupies bits [i*UMBRAL_W +: UMBRAL_W].
- `fifo_error`  in  NUM_FIFOS  per-FIFO overflow/error flag.
- `fifo_empty`  in  NUM_FIFOS  per-FIFO empty flag.
- `umbrales_out`  out  NUM_FIFOS*UMBRAL_W  latched thresholds.
- `state_out`  out  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- `idle_out`  out  1  high iff state is IDLE.
- `active_out`  out  1  high iff state is ACTIVE.
- `error_out`  out  1  high iff state is ERROR.
- `error_src`  out  NUM_FIFOS  sticky record of the FIFOs that raised an error.
- `err_count`  out  ERR_CNT_W  count of entries into ERROR.

## Operation
- Priority per edge, highest first: reset, then `init`, then any error, then the empty flags.
- While `reset_L`=0: state=RESET, and every output is 0, including `umbrales_out`, `error_src` and `err_count`.
- RESET → INIT unconditionally on the next edge with `reset_L`=1.
- `init`=1 in any state → INIT. On entry to INIT, `error_src` clears; `err_count` does not.
- In INIT, `umbrales_out` <= `umbrales_in` on every edge.
  - Stays in INIT while `init`=1.
  - When `init`=0: go to ERROR if |`fifo_error`, else go to IDLE.
- `umbrales_out` holds its value in every state other than INIT and RESET.
- IDLE:
  - |`fifo_error` → ERROR.
  - Otherwise, if `fifo_empty` is not all ones → ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE:
  - |`fifo_error` → ERROR.
  - Otherwise, if `fifo_empty` is all ones → IDLE.
  - Otherwise stay in ACTIVE.
- ERROR is absorbing. It is left only through `reset_L`=0 (→ RESET) or `init`=1 (→ INIT). Deasserting `fifo_error` does not leave ERROR.
- `error_src` <= `error_src` | `fifo_error` on every edge in INIT, IDLE, ACTIVE and ERROR, except on the edge that enters INIT via `init`, where it clears.
- Unreachable `state_out` encodings (5–7) → RESET on the next edge.

## Timing
- Moore machine. Status outputs are registered and decoded from the next state, so `state_out`, `idle_out`, `active_out` and `error_out` change on the same edge as the state register.
- Latency: an input change at edge k is reflected on the outputs after edge k+1; one-cycle reaction.
- Exactly one of `idle_out`, `active_out`, `error_out` is high in IDLE, ACTIVE and ERROR. All three are 0 in RESET and INIT.
- Errors and empty flags are checked in the same cycle; error wins.
- `reset_L`=0 with `init`=1 → RESET.
- Reset mid-operation clears all state within one edge. No partial values are retained.

## Configuration
- `FSM_ERR_COUNT_EN` defined:
  - `err_count` increments by 1 on each transition into ERROR from INIT, IDLE or ACTIVE.
  - Saturates at 2^ERR_CNT_W−1.
  - Cleared only by reset.
- `FSM_ERR_COUNT_EN` undefined: `err_count` is tied to 0, the counter logic is absent, and the port remains.

## Test plan
- Reset: hold `reset_L`=0 for 2 cycles with `init`=1 and `fifo_error`=5'h1F → all outputs 0, `state_out`=0. Release → `state_out`=1 after one edge.
- Init latch: `init`=1 for 3 cycles with `umbrales_in`=20'hA5C3E, then 0, with `fifo_error`=0 and `fifo_empty`=5'h1F → `umbrales_out`=20'hA5C3E, then IDLE with `idle_out`=1. A later change of `umbrales_in` to 0 leaves `umbrales_out` unchanged.
- Activity: from IDLE, `fifo_empty`=5'h1D → ACTIVE one edge later with `active_out`=1. `fifo_empty`=5'h1F → IDLE one edge later.
- Error capture: in ACTIVE, `fifo_error`=5'h04 for one cycle, then 0 → ERROR, `error_out`=1 and `error_src`=5'h04. Remains in ERROR for 10 cycles.
- Error priority and recovery: in IDLE, `fifo_error`=5'h10 with `fifo_empty`=5'h00 → ERROR, not ACTIVE. Then `init`=1 → INIT with `error_src`=0.
- Counter (`FSM_ERR_COUNT_EN`, `ERR_CNT_W`=2): five error entries, each recovered via `init` → `err_count` reads 1, 2, 3, 3, 3. With the macro undefined, `err_count` stays 0.
